grant_burst_mux_2: RTL and testbench

Downstream companion of the 2-requester fixed-priority arbiter. It consumes the registered one-hot `grant` vector and locks onto the granted requester for one burst. It moves that requester's data beats through a registered valid/ready output stage, then signals completion so the arbiter side can re-arbitrate. Grant changes during a burst are ignored until the burst fully drains.

---
 rtl/grant_burst_mux_2.sv | 99 +++++++++
 tb/tb_grant_burst_mux_2.sv | 91 +++++++++
 2 files changed

// File: rtl/grant_burst_mux_2.sv
// grant_burst_mux_2: locks onto a one-hot grant and forwards one burst through a registered valid/ready stage
module grant_burst_mux_2 #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        grant,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_id,
  output logic              out_last,
  output logic [1:0]        done,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_id_q, out_id_d, out_last_q, out_last_d;
  logic [1:0] done_q, done_d;
  logic rdy, acc, last;
  assign rdy = !out_valid_q || out_ready;
  assign acc = state_q == XFER && req_valid[owner_q] && rdy;
  assign last = cnt_q == len_q;
  assign req_ready = (state_q == XFER && rdy) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_id = out_id_q;
  assign out_last = out_last_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    len_d = len_q;
    cnt_d = cnt_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    out_id_d = out_id_q;
    out_last_d = out_last_q;
    done_d = 2'b00;
    case (state_q)
      IDLE: if (grant == 2'b01 || grant == 2'b10) begin
        owner_d = grant[1];
        len_d = grant[1] ? req_len1 : req_len0;
        cnt_d = '0;
        state_d = XFER;
      end
      XFER: if (acc) begin
        out_data_d = owner_q ? req_data1 : req_data0;
        out_id_d = owner_q;
        out_valid_d = 1'b1;
        out_last_d = last;
        cnt_d = last ? cnt_q : cnt_q + 1'b1;
        state_d = last ? DRAIN : XFER;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      DRAIN: if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        done_d = owner_q ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_id_q <= 1'b0;
      out_last_q <= 1'b0;
      done_q <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_id_q <= out_id_d;
      out_last_q <= out_last_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_grant_burst_mux_2.sv
// tb_grant_burst_mux_2: directed scenarios plus random traffic against a burst-level reference model
module tb_grant_burst_mux_2;
  logic clk = 0, rst = 1, out_ready = 0, out_valid, out_id, out_last, busy;
  logic [1:0] grant = 0, req_valid = 0, req_ready, done;
  logic [3:0] req_len0 = 0, req_len1 = 0;
  logic [7:0] req_data0 = 0, req_data1 = 0, out_data;
  int n_chk = 0, n_fail = 0;
  bit m_busy, m_own, m_ov, m_olast, m_oid;
  logic [7:0] m_od;
  logic [1:0] m_done;
  int m_left;
  always #5 clk = ~clk;
  grant_burst_mux_2 dut (
    .clk(clk), .rst(rst), .grant(grant), .req_len0(req_len0), .req_len1(req_len1),
    .req_data0(req_data0), .req_data1(req_data1), .req_valid(req_valid), .req_ready(req_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_last(out_last), .done(done), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ov = 0; m_olast = 0; m_oid = 0; m_od = 0; m_done = 0; m_left = 0;
  endtask
  task automatic step(input logic r, input logic [1:0] g, input logic [1:0] v, input logic ordy,
                      input logic [3:0] l0, input logic [3:0] l1);
    logic [1:0] er;
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_id", out_id, m_oid);
    check("out_last", out_last, m_olast);
    check("done", done, m_done);
    check("busy", busy, m_busy);
    rst = r; grant = g; req_valid = v; out_ready = ordy; req_len0 = l0; req_len1 = l1;
    req_data0 = 8'($urandom); req_data1 = 8'($urandom);
    #1;
    er = (m_busy && m_left > 0 && (!m_ov || ordy)) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", req_ready, er);
    if (r) model_reset();
    else begin
      m_done = 0;
      if (!m_busy) begin
        if (g == 2'b01 || g == 2'b10) begin
          m_busy = 1; m_own = g[1]; m_left = (g[1] ? l1 : l0) + 1;
        end
      end else if (m_left > 0) begin
        if (v[m_own] && (!m_ov || ordy)) begin
          m_ov = 1; m_od = m_own ? req_data1 : req_data0; m_oid = m_own;
          m_olast = m_left == 1; m_left--;
        end else if (ordy) m_ov = 0;
      end else if (m_ov && ordy) begin
        m_ov = 0; m_done = m_own ? 2'b10 : 2'b01; m_busy = 0;
      end
    end
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    repeat (2) step(1, 2'b00, 2'b00, 1, 0, 0);
    repeat (3) step(0, 2'b00, 2'b00, 1, 0, 0);
    step(0, 2'b01, 2'b01, 1, 3, 0);
    repeat (7) step(0, 2'b00, 2'b01, 1, 3, 0);
    step(0, 2'b10, 2'b10, 1, 0, 1);
    step(0, 2'b00, 2'b10, 1, 0, 1);
    repeat (3) step(0, 2'b00, 2'b10, 0, 0, 1);
    repeat (5) step(0, 2'b00, 2'b10, 1, 0, 1);
    step(0, 2'b01, 2'b01, 1, 5, 2);
    for (int i = 0; i < 14; i++) step(0, i[0] ? 2'b11 : 2'b10, 2'b11, 1'($urandom), 5, 2);
    repeat (10) step(0, 2'b00, 2'b11, 1, 5, 2);
    repeat (3) step(0, 2'b11, 2'b11, 1, 5, 2);
    step(0, 2'b01, 2'b01, 1, 15, 0);
    repeat (20) step(0, 2'b00, 2'b01, 1, 15, 0);
    step(0, 2'b01, 2'b01, 1, 3, 0);
    repeat (2) step(0, 2'b00, 2'b01, 1, 3, 0);
    step(1, 2'b00, 2'b01, 1, 3, 0);
    step(0, 2'b10, 2'b10, 1, 3, 2);
    repeat (7) step(0, 2'b00, 2'b10, 1, 3, 2);
    repeat (3000) step($urandom_range(0, 199) == 0, 2'($urandom), 2'($urandom),
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 7) == 0 ? 4'hf : 4'($urandom_range(0, 4)),
                       $urandom_range(0, 7) == 0 ? 4'hf : 4'($urandom_range(0, 4)));
    step(0, 2'b00, 2'b00, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
